// File: rtl/present_pkg.sv
// Shared types and index helpers for the parametrised PRESENT bit-permutation layer.
package present_pkg;

  localparam int PRESENT_STATE_W = 64;

  typedef logic [PRESENT_STATE_W-1:0] present_state_t;

  // Destination of source bit i under the forward permutation; the top bit is a fixed point.
  function automatic int player_fwd_idx(input int i, input int w);
    if (i == w - 1) begin
      return w - 1;
    end else begin
      return (i * (w / 4)) % (w - 1);
    end
  endfunction

  function automatic int player_inv_idx(input int j, input int w);
    if (j == w - 1) begin
      return w - 1;
    end else begin
      return (j * 4) % (w - 1);
    end
  endfunction

endpackage

// File: rtl/present_pipe_stage.sv
// One elastic register stage: valid, data, direction flag and, with PRESENT_PLAYER_PARITY_EN,
// a parity bit. The stage loads whenever its load enable (empty or draining) is high.
module present_pipe_stage #(
  parameter int W = 64
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         i_load,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  input  logic         i_inv,
`ifdef PRESENT_PLAYER_PARITY_EN
  input  logic         i_par,
  output logic         o_par,
`endif
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_inv
);

  logic         r_valid;
  logic [W-1:0] r_data;
  logic         r_inv;

  // Payload only changes on a real transfer so a stalled output stays stable.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_inv   <= 1'b0;
    end else if (i_load) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_data;
        r_inv  <= i_inv;
      end
    end
  end

`ifdef PRESENT_PLAYER_PARITY_EN
  logic r_par;

  // Parity travels with its payload.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_par <= 1'b0;
    end else if (i_load && i_valid) begin
      r_par <= i_par;
    end
  end

  assign o_par = r_par;
`endif

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_inv   = r_inv;

endmodule

// File: rtl/present_player_pipe_chk.sv
// Protocol checker: a stalled input offer must stay asserted and unchanged until accepted.
module present_player_pipe_chk #(
  parameter int W = 64
) (
  input logic         clock,
  input logic         reset_n,
  input logic         i_valid,
  input logic         i_ready,
  input logic [W-1:0] i_state,
  input logic         i_inv
);

  a_in_hold: assert property (@(posedge clock) disable iff (!reset_n)
    (i_valid && !i_ready) |=> (i_valid && $stable(i_state) && $stable(i_inv)));

endmodule

// File: rtl/present_player_pipe.sv
// Pipelined PRESENT pLayer (forward or inverse per transaction) with valid/ready handshake.
// Optional parity tracking and sticky perm_err when PRESENT_PLAYER_PARITY_EN is defined.
module present_player_pipe
  import present_pkg::*;
#(
  parameter int STATE_W     = 64,
  parameter int PIPE_STAGES = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_state,
  input  logic               in_inv,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_state,
  output logic               out_inv,
  output logic               perm_err
);

  logic [STATE_W-1:0] w_fwd;
  logic [STATE_W-1:0] w_inv;
  logic [STATE_W-1:0] w_perm;
  logic [PIPE_STAGES:0] w_vin;
  logic [PIPE_STAGES:0] w_inv_c;
  logic [PIPE_STAGES-1:0] w_rdy;
  logic [STATE_W-1:0] w_dat [PIPE_STAGES+1];

  for (genvar gi = 0; gi < STATE_W; gi++) begin : g_perm
    localparam int FI = player_fwd_idx(gi, STATE_W);
    localparam int II = player_inv_idx(gi, STATE_W);
    assign w_fwd[FI] = in_state[gi];
    assign w_inv[II] = in_state[gi];
  end

  assign w_perm     = in_inv ? w_inv : w_fwd;
  assign w_vin[0]   = in_valid;
  assign w_dat[0]   = w_perm;
  assign w_inv_c[0] = in_inv;

`ifdef PRESENT_PLAYER_PARITY_EN
  logic [PIPE_STAGES:0] w_par;
  assign w_par[0] = ^in_state;
`endif

  // A stage may load when some stage at or after it is empty, or the sink is draining.
  for (genvar gk = 0; gk < PIPE_STAGES; gk++) begin : g_stage
    assign w_rdy[gk] = out_ready | ~(&w_vin[PIPE_STAGES:gk+1]);

    present_pipe_stage #(.W(STATE_W)) u_stage (
      .clock   (clock),
      .reset_n (reset_n),
      .i_load  (w_rdy[gk]),
      .i_valid (w_vin[gk]),
      .i_data  (w_dat[gk]),
      .i_inv   (w_inv_c[gk]),
`ifdef PRESENT_PLAYER_PARITY_EN
      .i_par   (w_par[gk]),
      .o_par   (w_par[gk+1]),
`endif
      .o_valid (w_vin[gk+1]),
      .o_data  (w_dat[gk+1]),
      .o_inv   (w_inv_c[gk+1])
    );
  end

  assign in_ready  = w_rdy[0];
  assign out_valid = w_vin[PIPE_STAGES];
  assign out_state = w_dat[PIPE_STAGES];
  assign out_inv   = w_inv_c[PIPE_STAGES];

`ifdef PRESENT_PLAYER_PARITY_EN
  logic r_perm_err;

  // A permutation preserves popcount, so parity of output must match parity of the input.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_perm_err <= 1'b0;
    end else if (out_valid && out_ready && ((^out_state) != w_par[PIPE_STAGES])) begin
      r_perm_err <= 1'b1;
    end
  end

  assign perm_err = r_perm_err;
`else
  assign perm_err = 1'b0;
`endif

  present_player_pipe_chk #(.W(STATE_W)) u_chk (
    .clock   (clock),
    .reset_n (reset_n),
    .i_valid (in_valid),
    .i_ready (in_ready),
    .i_state (in_state),
    .i_inv   (in_inv)
  );

endmodule

// File: tb/tb_present_player_pipe.sv
// Directed self-checking bench for present_player_pipe (64-bit and 16-bit instances).
module tb_present_player_pipe;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_state = 64'h0;
  logic        in_inv = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_state;
  logic        out_inv;
  logic        perm_err;

  logic        v16 = 1'b0;
  logic        r16;
  logic [15:0] s16 = 16'h0;
  logic        inv16 = 1'b0;
  logic        ov16;
  logic        ordy16 = 1'b1;
  logic [15:0] os16;
  logic        oi16;
  logic        pe16;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  present_player_pipe #(.STATE_W(64), .PIPE_STAGES(2)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_state(in_state), .in_inv(in_inv), .out_valid(out_valid), .out_ready(out_ready),
    .out_state(out_state), .out_inv(out_inv), .perm_err(perm_err)
  );

  present_player_pipe #(.STATE_W(16), .PIPE_STAGES(2)) dut16 (
    .clock(clock), .reset_n(reset_n), .in_valid(v16), .in_ready(r16),
    .in_state(s16), .in_inv(inv16), .out_valid(ov16), .out_ready(ordy16),
    .out_state(os16), .out_inv(oi16), .perm_err(pe16)
  );

  function automatic logic [63:0] pfwd(input logic [63:0] x);
    logic [63:0] r;
    r = 64'h0;
    for (int i = 0; i < 64; i++) begin
      r[(i == 63) ? 63 : ((i * 16) % 63)] = x[i];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic xfer(input logic [63:0] s, input logic inv, output logic [63:0] res,
                      output logic resinv);
    int n;
    in_valid  = 1'b1;
    in_state  = s;
    in_inv    = inv;
    out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) chk("accept_timeout", in_ready, 64'd1);
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    if (!out_valid) chk("emit_timeout", out_valid, 64'd1);
    res    = out_state;
    resinv = out_inv;
    tick();
  endtask

  logic [63:0] t1_in  [4];
  logic [63:0] t1_out [4];
  logic [63:0] sv [16];
  logic [63:0] a, b, c, x, y, z;
  logic        yi, zi;
  int          errs;

  initial begin
    t1_in  = '{64'h1, 64'h2, 64'h10, 64'h8000_0000_0000_0000};
    t1_out = '{64'h1, 64'h1_0000, 64'h2, 64'h8000_0000_0000_0000};

    // reset state
    #12;
    chk("rst_out_valid", out_valid, 64'd0);
    chk("rst_out_state", out_state, 64'd0);
    chk("rst_out_inv", out_inv, 64'd0);
    chk("rst_perm_err", perm_err, 64'd0);
    #5 reset_n = 1'b1;
    tick();
    chk("rst_in_ready", in_ready, 64'd1);

    // 1: forward directed vectors with exact latency
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_state = t1_in[k]; in_inv = 1'b0; out_ready = 1'b1;
      chk("fwd_in_ready", in_ready, 64'd1);
      tick();
      in_valid = 1'b0;
      chk("fwd_lat1_valid", out_valid, 64'd0);
      tick();
      chk("fwd_lat2_valid", out_valid, 64'd1);
      chk("fwd_state", out_state, t1_out[k]);
      chk("fwd_inv", out_inv, 64'd0);
      tick();
      chk("fwd_drained", out_valid, 64'd0);
    end

    // 2: inverse directed then random round trips
    xfer(64'h1_0000, 1'b1, y, yi);
    chk("inv_state", y, 64'h2);
    chk("inv_flag", yi, 64'd1);
    errs = 0;
    for (int k = 0; k < 1000; k++) begin
      x = {$urandom(), $urandom()};
      xfer(x, 1'b0, y, yi);
      if (y !== pfwd(x) || yi !== 1'b0) errs++;
      xfer(y, 1'b1, z, zi);
      if (z !== x || zi !== 1'b1) errs++;
    end
    chk("roundtrip_errs", errs, 64'd0);

    // 3: streaming at full throughput
    out_ready = 1'b1;
    for (int k = 0; k < 18; k++) begin
      in_valid = (k < 16);
      if (k < 16) begin
        sv[k] = {16{4'(k)}} ^ 64'hDEAD_BEEF_0000_1234;
        in_state = sv[k];
      end
      in_inv = 1'b0;
      if (k < 16) chk("stream_in_ready", in_ready, 64'd1);
      tick();
      if (k >= 1 && k <= 16) begin
        chk("stream_out_valid", out_valid, 64'd1);
        chk("stream_out_state", out_state, pfwd(sv[k-1]));
      end else begin
        chk("stream_idle", out_valid, 64'd0);
      end
    end
    in_valid = 1'b0;

    // 4: backpressure fills exactly PIPE_STAGES entries
    a = 64'h0123_4567_89AB_CDEF; b = 64'hFEDC_BA98_7654_3210; c = 64'h0F0F_00FF_F0F0_1357;
    out_ready = 1'b0;
    in_valid = 1'b1; in_state = a; in_inv = 1'b0;
    chk("bp_acc_a", in_ready, 64'd1);
    tick();
    in_state = b;
    chk("bp_acc_b", in_ready, 64'd1);
    tick();
    in_state = c;
    chk("bp_full", in_ready, 64'd0);
    tick();
    tick();
    chk("bp_hold_valid", out_valid, 64'd1);
    chk("bp_hold_state", out_state, pfwd(a));
    chk("bp_still_full", in_ready, 64'd0);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 64'd1);
    chk("bp_out_a", out_state, pfwd(a));
    tick();
    in_valid = 1'b0;
    chk("bp_valid_b", out_valid, 64'd1);
    chk("bp_out_b", out_state, pfwd(b));
    tick();
    chk("bp_valid_c", out_valid, 64'd1);
    chk("bp_out_c", out_state, pfwd(c));
    tick();
    chk("bp_empty", out_valid, 64'd0);

    // 5: reset with two transactions in flight
    out_ready = 1'b0;
    in_valid = 1'b1; in_state = a;
    tick();
    in_state = b;
    tick();
    in_valid = 1'b0;
    chk("mid_inflight", out_valid, 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 64'd0);
    chk("mid_rst_state", out_state, 64'd0);
    tick();
    reset_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("mid_post_valid", out_valid, 64'd0);
    chk("mid_post_ready", in_ready, 64'd1);

    // 6: 16-bit instance
    v16 = 1'b1; s16 = 16'h0002; inv16 = 1'b0; ordy16 = 1'b1;
    tick();
    v16 = 1'b0;
    tick();
    chk("w16_valid", ov16, 64'd1);
    chk("w16_fwd", os16, 64'h0010);
    chk("w16_inv_flag", oi16, 64'd0);
    tick();
    v16 = 1'b1; s16 = 16'h0010; inv16 = 1'b1;
    tick();
    v16 = 1'b0;
    tick();
    chk("w16_inv", os16, 64'h0002);
    chk("w16_inv_flag1", oi16, 64'd1);
    for (int k = 0; k < 1000; k++) begin
      v16 = 1'b1; s16 = 16'($urandom()); inv16 = 1'($urandom());
      tick();
    end
    v16 = 1'b0;
    tick();
    tick();
    chk("w16_perm_err", pe16, 64'd0);
    chk("w64_perm_err", perm_err, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
